// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU select codes, RV32I opcode constants and the issue-entry record
// for the decode/issue stage.
package alu_issue_stage_pkg;

  localparam logic [4:0] ALU_add  = 5'd0;
  localparam logic [4:0] ALU_sub  = 5'd1;
  localparam logic [4:0] ALU_sll  = 5'd2;
  localparam logic [4:0] ALU_slt  = 5'd3;
  localparam logic [4:0] ALU_sltu = 5'd4;
  localparam logic [4:0] ALU_xor  = 5'd5;
  localparam logic [4:0] ALU_srl  = 5'd6;
  localparam logic [4:0] ALU_sra  = 5'd7;
  localparam logic [4:0] ALU_or   = 5'd8;
  localparam logic [4:0] ALU_and  = 5'd9;
  localparam logic [4:0] ALU_addi = 5'd10;
  localparam logic [4:0] ALU_ori  = 5'd11;
  localparam logic [4:0] ALU_andi = 5'd12;
  localparam logic [4:0] ALU_slli = 5'd13;
  localparam logic [4:0] ALU_srli = 5'd14;
  localparam logic [4:0] ALU_srai = 5'd15;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  select;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
  } issue_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of ALU-class RV32I instructions into ALU operands,
// select code and writeback control.
module alu_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output issue_t      dec
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  sel;
  logic        ill;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_u  = {instr[31:12], 12'b0};

  always_comb begin
    a   = '0;
    b   = '0;
    sel = ALU_add;
    ill = 1'b0;
    case (opcode)
      OPC_OP: begin
        a = rs1_data;
        b = rs2_data;
        // Only add/sub and srl/sra have an alternate funct7 encoding.
        if (!(funct7 == 7'b0000000 ||
              (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))) begin
          ill = 1'b1;
        end
        case (funct3)
          3'b000:  sel = funct7[5] ? ALU_sub : ALU_add;
          3'b001:  begin sel = ALU_sll; b = {27'b0, rs2_data[4:0]}; end
          3'b010:  sel = ALU_slt;
          3'b011:  sel = ALU_sltu;
          3'b100:  sel = ALU_xor;
          3'b101:  begin sel = funct7[5] ? ALU_sra : ALU_srl; b = {27'b0, rs2_data[4:0]}; end
          3'b110:  sel = ALU_or;
          default: sel = ALU_and;
        endcase
      end
      OPC_OPIMM: begin
        a = rs1_data;
        b = imm_i;
        case (funct3)
          3'b000:  sel = ALU_addi;
          3'b001: begin
            sel = ALU_slli;
            b   = {27'b0, instr[24:20]};
            ill = (funct7 != 7'b0000000);
          end
          3'b010:  sel = ALU_slt;
          3'b011:  sel = ALU_sltu;
          3'b100:  sel = ALU_xor;
          3'b101: begin
            sel = funct7[5] ? ALU_srai : ALU_srli;
            b   = {27'b0, instr[24:20]};
            ill = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
          end
          3'b110:  sel = ALU_ori;
          default: sel = ALU_andi;
        endcase
      end
      OPC_LUI: begin
        a = '0;
        b = imm_u;
      end
      OPC_AUIPC: begin
        a = pc;
        b = imm_u;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      a   = '0;
      b   = '0;
      sel = ALU_add;
    end
  end

  assign dec.a         = a;
  assign dec.b         = b;
  assign dec.select    = sel;
  assign dec.rd        = instr[11:7];
  assign dec.reg_write = !ill && (instr[11:7] != 5'd0);
  assign dec.illegal   = ill;

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage: decodes ALU instructions and holds them in a two-entry skid
// buffer so in_ready never depends combinationally on out_ready.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_select,
  output logic [4:0]  rd,
  output logic        reg_write,
  output logic        illegal
);

  issue_t dec;
  issue_t head_q, head_d, skid_q, skid_d;
  logic   head_valid_q, head_valid_d, skid_valid_q, skid_valid_d;
  logic   accept, pop;

  alu_decode u_decode (
    .instr    (instr),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .dec      (dec)
  );

  assign in_ready = !skid_valid_q && !rst;
  assign accept   = in_valid && in_ready && !flush;
  assign pop      = head_valid_q && out_ready;

  always_comb begin
    head_d       = head_q;
    skid_d       = skid_q;
    head_valid_d = head_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!head_valid_q || pop) begin
      // Skid is only ever full when head is, and then in_ready blocks accept.
      if (skid_valid_q) begin
        head_d       = skid_q;
        head_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        head_d       = dec;
        head_valid_d = 1'b1;
      end else begin
        head_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      skid_q       <= '0;
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      skid_q       <= skid_d;
      head_valid_q <= head_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid  = head_valid_q;
  assign alu_a      = head_q.a;
  assign alu_b      = head_q.b;
  assign alu_select = head_q.select;
  assign rd         = head_q.rd;
  assign reg_write  = head_q.reg_write;
  assign illegal    = head_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vector table plus backpressure,
// flush and mid-stream reset sequences.
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data, alu_a, alu_b;
  logic [4:0]  alu_select, rd;
  logic        reg_write, illegal;

  int checks = 0;
  int errors = 0;

  alu_issue_stage dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .pc         (pc),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_select (alu_select),
    .rd         (rd),
    .reg_write  (reg_write),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sel;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } vec_t;

  vec_t vecs[13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2);
    in_valid = 1'b1;
    instr    = i;
    rs1_data = r1;
    rs2_data = r2;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, " alu_a"}, alu_a, 32'd0);
    check({tag, " alu_b"}, alu_b, 32'd0);
    check({tag, " alu_select"}, {27'b0, alu_select}, 32'd0);
    check({tag, " rd"}, {27'b0, rd}, 32'd0);
    check({tag, " reg_write"}, {31'b0, reg_write}, 32'd0);
    check({tag, " illegal"}, {31'b0, illegal}, 32'd0);
    check({tag, " in_ready"}, {31'b0, in_ready}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{32'h002081B3, 32'h0, 32'd5, 32'd7, 32'd5, 32'd7, ALU_add, 5'd3, 1'b1, 1'b0};
    vecs[1]  = '{32'hFFF00093, 32'h0, 32'h11, 32'h0, 32'h11, 32'hFFFFFFFF, ALU_addi, 5'd1, 1'b1,
                 1'b0};
    vecs[2]  = '{32'h4020D233, 32'h0, 32'h80000000, 32'h25, 32'h80000000, 32'd5, ALU_sra, 5'd4,
                 1'b1, 1'b0};
    vecs[3]  = '{32'h123452B7, 32'h0, 32'hDEAD, 32'hBEEF, 32'h0, 32'h12345000, ALU_add, 5'd5,
                 1'b1, 1'b0};
    vecs[4]  = '{32'h0000007F, 32'h0, 32'h1234, 32'h5678, 32'h0, 32'h0, ALU_add, 5'd0, 1'b0, 1'b1};
    vecs[5]  = '{32'h00001397, 32'h100, 32'h9, 32'h9, 32'h100, 32'h1000, ALU_add, 5'd7, 1'b1, 1'b0};
    vecs[6]  = '{32'h4030D313, 32'h0, 32'h55, 32'h0, 32'h55, 32'd3, ALU_srai, 5'd6, 1'b1, 1'b0};
    vecs[7]  = '{32'h40208033, 32'h0, 32'd9, 32'd4, 32'd9, 32'd4, ALU_sub, 5'd0, 1'b0, 1'b0};
    vecs[8]  = '{32'h4020F0B3, 32'h0, 32'd9, 32'd4, 32'h0, 32'h0, ALU_add, 5'd1, 1'b0, 1'b1};
    vecs[9]  = '{32'h0050B113, 32'h0, 32'd7, 32'd0, 32'd7, 32'd5, ALU_sltu, 5'd2, 1'b1, 1'b0};
    vecs[10] = '{32'h00209433, 32'h0, 32'd3, 32'hFFFFFFE1, 32'd3, 32'd1, ALU_sll, 5'd8, 1'b1, 1'b0};
    vecs[11] = '{32'hFF00F493, 32'h0, 32'hAB, 32'd0, 32'hAB, 32'hFFFFFFF0, ALU_andi, 5'd9, 1'b1,
                 1'b0};
    vecs[12] = '{32'h40109093, 32'h0, 32'd1, 32'd2, 32'h0, 32'h0, ALU_add, 5'd1, 1'b0, 1'b1};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
    step();
    step();
    check_zero_outputs("reset");
    rst = 1'b0;
    #1;
    check("in_ready after release", {31'b0, in_ready}, 32'd1);

    // Decode table: one instruction per cycle with out_ready held high.
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].instr, vecs[i].rs1, vecs[i].rs2);
      pc = vecs[i].pc;
      step();
      check($sformatf("v%0d out_valid", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("v%0d alu_a", i), alu_a, vecs[i].a);
      check($sformatf("v%0d alu_b", i), alu_b, vecs[i].b);
      check($sformatf("v%0d alu_select", i), {27'b0, alu_select}, {27'b0, vecs[i].sel});
      check($sformatf("v%0d rd", i), {27'b0, rd}, {27'b0, vecs[i].rd});
      check($sformatf("v%0d reg_write", i), {31'b0, reg_write}, {31'b0, vecs[i].rw});
      check($sformatf("v%0d illegal", i), {31'b0, illegal}, {31'b0, vecs[i].ill});
    end
    in_valid = 1'b0;
    pc = '0;
    step();
    check("drained out_valid", {31'b0, out_valid}, 32'd0);

    // Backpressure: I0/I1 fill head and skid, I2 waits until space frees.
    out_ready = 1'b0;
    drive(32'h002081B3, 32'd100, 32'd0);
    step();
    check("bp in_ready after I0", {31'b0, in_ready}, 32'd1);
    drive(32'h002081B3, 32'd101, 32'd0);
    step();
    check("bp in_ready after I1", {31'b0, in_ready}, 32'd0);
    drive(32'h002081B3, 32'd102, 32'd0);
    step();
    check("bp head held", alu_a, 32'd100);
    check("bp still full", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    step();
    check("bp order I1", alu_a, 32'd101);
    check("bp I1 valid", {31'b0, out_valid}, 32'd1);
    step();
    check("bp order I2", alu_a, 32'd102);
    check("bp I2 valid", {31'b0, out_valid}, 32'd1);
    in_valid = 1'b0;
    step();
    check("bp empty", {31'b0, out_valid}, 32'd0);

    // Flush with both entries full plus a same-cycle input.
    out_ready = 1'b0;
    drive(32'h002081B3, 32'd200, 32'd0);
    step();
    drive(32'h002081B3, 32'd201, 32'd0);
    step();
    drive(32'h002081B3, 32'd202, 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush out_valid", {31'b0, out_valid}, 32'd0);
    check("flush in_ready", {31'b0, in_ready}, 32'd1);
    step();
    check("flush input dropped", {31'b0, out_valid}, 32'd0);

    // Reset mid-stream, then a normal issue.
    drive(32'h002081B3, 32'd300, 32'd0);
    step();
    drive(32'h002081B3, 32'd301, 32'd0);
    step();
    rst = 1'b1;
    drive(32'h002081B3, 32'd302, 32'd0);
    step();
    check_zero_outputs("mid reset");
    rst = 1'b0;
    out_ready = 1'b1;
    drive(32'h002081B3, 32'd42, 32'd1);
    #1;
    check("post reset in_ready", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("post reset out_valid", {31'b0, out_valid}, 32'd1);
    check("post reset alu_a", alu_a, 32'd42);
    check("post reset rd", {27'b0, rd}, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
